// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: execute-stage ALU with a registered result, valid/ready handshake
// and an iterative RV32M-style multiply/divide unit.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   i_flush            synchronous abort of any in-flight op and pending result
//   in_valid/in_ready  operand handshake; an op is taken when both are high
//   i_1, i_2           operands A and B (XLEN bits)
//   aluSel             5-bit operation code
//   out_valid/out_ready result handshake; result is held while not consumed
//   result, zero_flag  registered result and its "equals zero" flag
//
// Single-cycle ops (and divide special cases) write the result register in
// the accept cycle. Multiply/divide latch operand magnitudes, iterate
// XLEN/UNROLL cycles in ITER, then apply the sign correction in FIX.
module alu_mdu_seq #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] i_1,
  input  logic [XLEN-1:0] i_2,
  input  logic [4:0]      aluSel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag
);

  localparam int SHW   = $clog2(XLEN);
  localparam int ITERS = XLEN / UNROLL;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t state, state_next;

  logic            accept, is_multi, is_div, div_by_zero, div_ovf, special, start_iter;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] one_cycle_val, fix_val;
  logic            sign_a, sign_b, neg_next;
  logic [XLEN-1:0] mag_a, mag_b;

  logic [XLEN-1:0] acc, lo, dvsr;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0]   it_acc, it_lo, addend;
  logic [XLEN:0]     sum, shifted;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign shamt       = i_2[SHW-1:0];
  assign accept      = in_valid && in_ready && !i_flush;
  assign is_multi    = (aluSel[4:3] == 2'b10);
  assign is_div      = is_multi && aluSel[2];
  assign div_by_zero = (i_2 == '0);
  // Signed overflow exists only for DIV/REM (10100 / 10110)
  assign div_ovf     = is_div && !aluSel[0] && (i_1 == MIN_NEG) && (i_2 == '1);
  assign special     = is_div && (div_by_zero || div_ovf);
  assign start_iter  = accept && is_multi && !special;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; DONE accepts a new op in the cycle its result is consumed
  always_comb begin
    state_next = state;
    if (i_flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        ITER: if (cnt == CW'(ITERS - 1)) state_next = FIX;
        FIX:  state_next = DONE;
        default: begin
          if (accept)                          state_next = start_iter ? ITER : DONE;
          else if (state == DONE && out_ready) state_next = IDLE;
        end
      endcase
    end
  end

  // Handshake outputs
  always_comb begin
    out_valid = (state == DONE);
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  end

  // Single-cycle results, including the divide special cases
  always_comb begin
    one_cycle_val = '0;
    case (aluSel)
      5'b00000: one_cycle_val = i_1 & i_2;
      5'b00001: one_cycle_val = i_1 | i_2;
      5'b01001: one_cycle_val = i_1 ^ i_2;
      5'b00010: one_cycle_val = i_1 + i_2;
      5'b00011: one_cycle_val = i_1 - i_2;
      5'b00100: one_cycle_val = XLEN'(i_1 < i_2);
      5'b01011: one_cycle_val = XLEN'($signed(i_1) < $signed(i_2));
      5'b00101: one_cycle_val = i_2;
      5'b00111: one_cycle_val = (i_2 << 12) + i_1;
      5'b01000: one_cycle_val = i_1 << shamt;
      5'b01010: one_cycle_val = i_1 >> shamt;
      5'b01100: one_cycle_val = $unsigned($signed(i_1) >>> shamt);
      5'b10100: one_cycle_val = div_by_zero ? '1 : MIN_NEG;
      5'b10101: one_cycle_val = '1;
      5'b10110: one_cycle_val = div_by_zero ? i_1 : '0;
      5'b10111: one_cycle_val = i_1;
      default:  one_cycle_val = '0;
    endcase
  end

  // Operand signedness and final negation flag for the iterative path
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (aluSel[2:0])
      3'b001, 3'b100, 3'b110: begin
        sign_a = i_1[XLEN-1];
        sign_b = i_2[XLEN-1];
      end
      3'b010:  sign_a = i_1[XLEN-1];
      default: ;
    endcase
    mag_a    = sign_a ? -i_1 : i_1;
    mag_b    = sign_b ? -i_2 : i_2;
    // Remainder takes the dividend's sign; everything else the product of signs
    neg_next = (aluSel[2:0] == 3'b110) ? sign_a : (sign_a ^ sign_b);
  end

  // UNROLL steps of shift-add multiply or restoring divide.
  // Multiply: acc = high half, lo = multiplier shifting out / product low half.
  // Divide:   acc = partial remainder, lo = dividend shifting out / quotient.
  always_comb begin
    it_acc  = acc;
    it_lo   = lo;
    addend  = '0;
    sum     = '0;
    shifted = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (!op_q[2]) begin
        addend = it_lo[0] ? dvsr : '0;
        sum    = {1'b0, it_acc} + {1'b0, addend};
        it_lo  = {sum[0], it_lo[XLEN-1:1]};
        it_acc = sum[XLEN:1];
      end else begin
        shifted = {it_acc, it_lo[XLEN-1]};
        it_lo   = {it_lo[XLEN-2:0], 1'b0};
        if (shifted >= {1'b0, dvsr}) begin
          it_acc   = shifted[XLEN-1:0] - dvsr;
          it_lo[0] = 1'b1;
        end else begin
          it_acc = shifted[XLEN-1:0];
        end
      end
    end
  end

  // Sign correction and result selection applied in FIX
  always_comb begin
    prod     = {acc, lo};
    prod_fix = neg_q ? -prod : prod;
    case (op_q)
      3'b000:                 fix_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = neg_q ? -lo : lo;
      default:                fix_val = neg_q ? -acc : acc;
    endcase
  end

  // Iteration registers and the registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      lo        <= '0;
      dvsr      <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      zero_flag <= 1'b1;
    end else begin
      if (start_iter) begin
        acc   <= '0;
        lo    <= mag_a;
        dvsr  <= mag_b;
        op_q  <= aluSel[2:0];
        neg_q <= neg_next;
        cnt   <= '0;
      end else if (state == ITER) begin
        acc <= it_acc;
        lo  <= it_lo;
        cnt <= cnt + CW'(1);
      end

      if (accept && !start_iter) begin
        result    <= one_cycle_val;
        zero_flag <= (one_cycle_val == '0);
      end else if (state == FIX && !i_flush) begin
        result    <= fix_val;
        zero_flag <= (fix_val == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: directed and randomized bench for alu_mdu_seq (XLEN=32, UNROLL=1).
// A behavioural model tracks the single outstanding op (result and the cycle
// its output must appear); a negedge process compares every cycle.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] i_1 = '0;
  logic [31:0] i_2 = '0;
  logic [4:0]  aluSel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero_flag;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: one outstanding op at most
  bit          m_busy = 1'b0;
  int          m_due = 0;
  logic [31:0] m_res = '0;
  bit          mv, mr, ev, er;

  bit rand_bp = 1'b0;
  bit rand_flush = 1'b0;

  alu_mdu_seq #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .i_1(i_1), .i_2(i_2), .aluSel(aluSel),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Reference result straight from the RISC-V arithmetic definitions
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned up;
    logic [63:0]     pv;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b01001: r = a ^ b;
      5'b00010: r = a + b;
      5'b00011: r = a - b;
      5'b00100: r = (a < b) ? 32'd1 : 32'd0;
      5'b01011: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b00101: r = b;
      5'b00111: r = (b << 12) + a;
      5'b01000: r = a << b[4:0];
      5'b01010: r = a >> b[4:0];
      5'b01100: r = $signed(a) >>> b[4:0];
      5'b10000: begin pv = sa * sb; r = pv[31:0]; end
      5'b10001: begin pv = sa * sb; r = pv[63:32]; end
      5'b10010: begin pv = sa * longint'({32'b0, b}); r = pv[63:32]; end
      5'b10011: begin up = {32'b0, a} * {32'b0, b}; pv = up; r = pv[63:32]; end
      5'b10100: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else begin pv = sa / sb; r = pv[31:0]; end
      end
      5'b10101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      5'b10110: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else begin pv = sa % sb; r = pv[31:0]; end
      end
      5'b10111: r = (b == 0) ? a : a % b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Cycles from accept to out_valid
  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[4:3] != 2'b10) return 1;
    if (op[2] && b == 0) return 1;
    if ((op == 5'b10100 || op == 5'b10110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  // Model: asynchronous reset clears any outstanding op immediately
  always @(negedge rst_n) m_busy = 1'b0;

  // Model: advance one cycle at each rising edge using the sampled inputs
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
    end else begin
      mv = m_busy && (cyc >= m_due);
      mr = !m_busy || (mv && out_ready);
      if (i_flush) begin
        m_busy = 1'b0;
      end else begin
        if (mv && out_ready) m_busy = 1'b0;
        if (in_valid && mr) begin
          m_busy = 1'b1;
          m_due  = cyc + ref_latency(aluSel, i_1, i_2);
          m_res  = ref_result(aluSel, i_1, i_2);
        end
      end
    end
    cyc++;
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset result", result, 32'd0);
      checkOutput("reset zero_flag", {31'b0, zero_flag}, 32'd1);
    end else begin
      ev = m_busy && (cyc >= m_due);
      er = !m_busy || (ev && out_ready);
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, ev});
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, er});
      if (ev) begin
        checkOutput("result", result, m_res);
        checkOutput("zero_flag", {31'b0, zero_flag}, {31'b0, (m_res == 0)});
      end
    end
  end

  // Random backpressure and occasional flush during the random phase
  always @(posedge clk) begin
    #1;
    if (rand_bp)    out_ready = ($urandom_range(0, 3) != 0);
    if (rand_flush) i_flush   = ($urandom_range(0, 49) == 0);
  end

  // Present an op and hold it until the DUT takes it; returns at posedge+1
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    aluSel   = op;
    i_1      = a;
    i_2      = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: in_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Issue one op with the consumer ready and pin its result and latency
  task automatic runDirected(input string name, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    applyStimulus(op, a, b);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    checkOutput({name, " result"}, result, exp);
    checkOutput({name, " latency"}, lat, exp_lat);
    checkOutput({name, " zero_flag"}, {31'b0, zero_flag}, {31'b0, (exp == 0)});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] op_list [20] = '{5'b00000, 5'b00001, 5'b01001, 5'b00010, 5'b00011, 5'b00100,
                               5'b01011, 5'b00101, 5'b00111, 5'b01000, 5'b01010, 5'b01100,
                               5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101,
                               5'b10110, 5'b10111};

  initial begin
    // Watchdog so the run always ends with a summary
    #2000000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int w;
    int idle;

    // Pin the model against hand-computed values
    checkOutput("model MULHU", ref_result(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    checkOutput("model DIV", ref_result(5'b10100, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    checkOutput("model REM", ref_result(5'b10110, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    checkOutput("model SRA", ref_result(5'b01100, 32'h80000000, 32'd4), 32'hF8000000);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after reset", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed cases with literal expectations
    runDirected("ADD ovf", 5'b00010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1);
    runDirected("SUB zero", 5'b00011, 32'd5, 32'd5, 32'd0, 1);
    runDirected("MUL", 5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 34);
    runDirected("MULH", 5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 34);
    runDirected("MULHU", 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    runDirected("MULHSU", 5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    runDirected("DIV -7/2", 5'b10100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    runDirected("REM -7/2", 5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    runDirected("DIVU by 0", 5'b10101, 32'd7, 32'd0, 32'hFFFFFFFF, 1);
    runDirected("REMU by 0", 5'b10111, 32'd9, 32'd0, 32'd9, 1);
    runDirected("DIV ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    runDirected("REM ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    runDirected("SLL", 5'b01000, 32'h00000003, 32'h00000024, 32'h00000030, 1);
    runDirected("undef 11xxx", 5'b11010, 32'd3, 32'd4, 32'd0, 1);
    runDirected("undef 0xxxx", 5'b00110, 32'd3, 32'd4, 32'd0, 1);

    // Backpressure: result held for 5 cycles, then consume and accept together
    out_ready = 1'b0;
    applyStimulus(5'b00010, 32'd3, 32'd4);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp held result", result, 32'd7);
      checkOutput("bp in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    aluSel    = 5'b00011;
    i_1       = 32'd10;
    i_2       = 32'd4;
    in_valid  = 1'b1;
    @(negedge clk);
    checkOutput("bp same-cycle accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp next result", result, 32'd6);
    @(posedge clk);
    #1;

    // Flush during ITER cycle 10 of a DIV
    applyStimulus(5'b10100, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    @(negedge clk);
    checkOutput("flush in_ready", {31'b0, in_ready}, 32'd1);
    repeat (40) begin
      @(negedge clk);
      checkOutput("flush no result", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    runDirected("ADD after flush", 5'b00010, 32'd20, 32'd22, 32'd42, 1);

    // Flush wins over a simultaneous in_valid
    aluSel   = 5'b00010;
    i_1      = 32'd1;
    i_2      = 32'd1;
    in_valid = 1'b1;
    i_flush  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    i_flush  = 1'b0;
    @(negedge clk);
    checkOutput("flush beats in_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Reset pulse in the middle of a MUL
    applyStimulus(5'b10000, 32'd123, 32'd456);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async rst result", result, 32'd0);
    checkOutput("async rst zero_flag", {31'b0, zero_flag}, 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after mid-op reset", {31'b0, in_ready}, 32'd1);
    repeat (40) begin
      @(negedge clk);
      checkOutput("no stale out_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    runDirected("MUL after reset", 5'b10000, 32'd123, 32'd456, 32'd56088, 34);

    // Randomized traffic with backpressure and occasional flush
    rand_bp    = 1'b1;
    rand_flush = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0)
        applyStimulus(5'b11000 | 5'($urandom_range(0, 7)), pick_operand(), pick_operand());
      else
        applyStimulus(op_list[$urandom_range(0, 19)], pick_operand(), pick_operand());
      idle = $urandom_range(0, 2);
      repeat (idle) @(posedge clk);
      #1;
    end
    rand_bp    = 1'b0;
    rand_flush = 1'b0;
    @(posedge clk);
    #2;
    i_flush   = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (m_busy && w < 100) begin
      @(posedge clk);
      w++;
    end
    checkOutput("drain complete", {31'b0, m_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
